// File: rtl/sdram_read_arbiter_pkg.sv
// Shared types and defaults for the SDRAM read-port arbiter.
package sdram_read_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    localparam int  ADDR_W_DEF      = 22;
    localparam int  DATA_W_DEF      = 16;
    localparam int  TIMEOUT_CYC_DEF = 1024;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Timer width for a given timeout; never narrower than one bit.
    function automatic int timer_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/sdram_read_arbiter_rr_pick2.sv
// Two-way round-robin picker: single requester always wins, on contention
// the port that was not served last wins.
module rr_pick2
    import sdram_read_arbiter_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_gnt,
    output logic o_valid,
    output logic o_sel
);

    // Select the winning port from the current requests and the last grant.
    always_comb begin
        o_valid = i_req0 | i_req1;
        o_sel   = PORT0;
        if (i_req0 && i_req1) begin
            o_sel = ~i_last_gnt;
        end else if (i_req1) begin
            o_sel = PORT1;
        end
    end

endmodule

// File: rtl/sdram_read_arbiter.sv
// Shares the single read port of the SDRAM controller between two
// requesters. One read in flight at a time, round-robin between ports,
// and a timeout that recovers from a data_rdy that never arrives.
//
// state | meaning
// IDLE  | no read in flight, arbitrating requests
// ISSUE | grant pulse and controller command pulse, timer cleared
// WAIT  | waiting for controller data or timeout
// DONE  | rvalid/err pulse to the served port
module sdram_read_arbiter
    import sdram_read_arbiter_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic              req1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    output logic              gnt0_o,
    output logic              gnt1_o,
    output logic              rvalid0_o,
    output logic              rvalid1_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] sd_addr_o,
    output logic              sd_cmd_o,
    input  logic [DATA_W-1:0] sd_data_i,
    input  logic              sd_rdy_i
);

    localparam int              TW         = timer_width(TIMEOUT_CYC);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic              r_port;
    logic              r_last_gnt;
    logic [ADDR_W-1:0] r_sd_addr;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic [TW-1:0]     r_timer;

    logic              w_pick_valid;
    logic              w_pick_sel;
    logic              w_load;
    logic              w_capture;
    logic              w_timeout;
    logic              w_timer_clr;
    logic              w_timer_inc;

    rr_pick2 u_pick (
        .i_req0     (req0_i),
        .i_req1     (req1_i),
        .i_last_gnt (r_last_gnt),
        .o_valid    (w_pick_valid),
        .o_sel      (w_pick_sel)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and datapath strobes.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        w_timer_clr  = 1'b0;
        w_timer_inc  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_load       = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_timer_clr  = 1'b1;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // Data arriving on the expiry cycle still counts as success.
                if (sd_rdy_i) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_DONE;
                end else if (r_timer == TIMER_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_DONE;
                end else begin
                    w_timer_inc  = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Output decode; every pulse is a function of state and the served port.
    always_comb begin
        gnt0_o    = 1'b0;
        gnt1_o    = 1'b0;
        rvalid0_o = 1'b0;
        rvalid1_o = 1'b0;
        sd_cmd_o  = 1'b0;
        err_o     = 1'b0;
        busy_o    = (r_state != ST_IDLE);
        if (r_state == ST_ISSUE) begin
            sd_cmd_o = 1'b1;
            gnt0_o   = (r_port == PORT0);
            gnt1_o   = (r_port == PORT1);
        end
        if (r_state == ST_DONE) begin
            rvalid0_o = (r_port == PORT0);
            rvalid1_o = (r_port == PORT1);
            err_o     = r_err;
        end
    end

    assign sd_addr_o = r_sd_addr;
    assign rdata_o   = r_rdata;

    // Latch the winning port and its address when a read is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_port    <= PORT0;
            r_sd_addr <= '0;
        end else if (w_load) begin
            r_port    <= w_pick_sel;
            r_sd_addr <= (w_pick_sel == PORT1) ? addr1_i : addr0_i;
        end
    end

    // Read result: controller data on success, zero with err on timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_capture) begin
            r_rdata <= sd_data_i;
            r_err   <= 1'b0;
        end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
        end
    end

    // Round-robin history, updated once the served port has its result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_gnt <= PORT1;
        end else if (r_state == ST_DONE) begin
            r_last_gnt <= r_port;
        end
    end

    // WAIT-cycle counter; stops at the last value because WAIT is left there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (w_timer_clr) begin
            r_timer <= '0;
        end else if (w_timer_inc) begin
            r_timer <= r_timer + 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_read_arbiter.sv
// Directed bench for sdram_read_arbiter with hand-computed expectations.
module tb_sdram_read_arbiter;

    localparam int AW = 22;
    localparam int DW = 16;
    localparam int T  = 1024;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1;
    logic [AW-1:0] addr0, addr1;
    logic          gnt0, gnt1, rv0, rv1, err, busy, cmd;
    logic [DW-1:0] rdata;
    logic [AW-1:0] sd_addr;
    logic [DW-1:0] sd_data;
    logic          sd_rdy;

    int total = 0;
    int bad   = 0;
    int k;
    int seen;

    always #5 clk = ~clk;

    sdram_read_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req0_i    (req0),
        .addr0_i   (addr0),
        .req1_i    (req1),
        .addr1_i   (addr1),
        .gnt0_o    (gnt0),
        .gnt1_o    (gnt1),
        .rvalid0_o (rv0),
        .rvalid1_o (rv1),
        .rdata_o   (rdata),
        .err_o     (err),
        .busy_o    (busy),
        .sd_addr_o (sd_addr),
        .sd_cmd_o  (cmd),
        .sd_data_i (sd_data),
        .sd_rdy_i  (sd_rdy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input string tag);
        int n;
        n = 0;
        while (!(gnt0 | gnt1) && n < 8) begin
            step();
            n++;
        end
        chk(tag, 32'(gnt0 | gnt1), 32'd1);
    endtask

    initial begin
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
        addr0 = '0; addr1 = '0; sd_data = '0; sd_rdy = 1'b0;
        #1;
        chk("rst_pulses", 32'({gnt0, gnt1, rv0, rv1, err, busy, cmd}), 32'd0);
        chk("rst_addr",   32'(sd_addr), 32'd0);
        chk("rst_rdata",  32'(rdata),   32'd0);
        step();
        step();
        reset = 1'b0;

        // Both ports contending: port 0 first after reset, then alternate.
        req0 = 1'b1; addr0 = 22'h000100;
        req1 = 1'b1; addr1 = 22'h000200;
        for (int i = 0; i < 4; i++) begin
            wait_gnt("rr_gnt_seen");
            chk("rr_gnt0", 32'(gnt0), 32'((i % 2) == 0));
            chk("rr_gnt1", 32'(gnt1), 32'((i % 2) == 1));
            chk("rr_addr", 32'(sd_addr), ((i % 2) == 0) ? 32'h100 : 32'h200);
            sd_rdy = 1'b1; sd_data = 16'h1000 + 16'(i);
            step();
            chk("rr_no_early_rv", 32'(rv0 | rv1), 32'd0);
            step();
            chk("rr_rv0", 32'(rv0), 32'((i % 2) == 0));
            chk("rr_rv1", 32'(rv1), 32'((i % 2) == 1));
            chk("rr_data", 32'(rdata), 32'h1000 + 32'(i));
            chk("rr_err", 32'(err), 32'd0);
            sd_rdy = 1'b0;
            if (i == 3) begin
                req0 = 1'b0; req1 = 1'b0;
            end
            step();
            chk("rr_idle", 32'(busy), 32'd0);
        end

        // Single port 0 read, data five cycles after the command.
        req0 = 1'b1; addr0 = 22'd1024;
        step();
        chk("p0_gnt0", 32'(gnt0), 32'd1);
        chk("p0_gnt1", 32'(gnt1), 32'd0);
        chk("p0_cmd",  32'(cmd),  32'd1);
        chk("p0_addr", 32'(sd_addr), 32'd1024);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            seen = seen | 32'(rv0 | rv1 | cmd);
        end
        chk("p0_wait_quiet", 32'(seen), 32'd0);
        chk("p0_addr_held", 32'(sd_addr), 32'd1024);
        sd_rdy = 1'b1; sd_data = 16'hA55A;
        step();
        chk("p0_rv0",  32'(rv0), 32'd1);
        chk("p0_rv1",  32'(rv1), 32'd0);
        chk("p0_data", 32'(rdata), 32'hA55A);
        chk("p0_err",  32'(err), 32'd0);
        req0 = 1'b0; sd_rdy = 1'b0;
        step();
        chk("p0_rv_drop", 32'(rv0), 32'd0);
        chk("p0_data_hold", 32'(rdata), 32'hA55A);

        // Stray data_rdy while idle is ignored.
        sd_rdy = 1'b1; sd_data = 16'hFFFF;
        step();
        chk("stray_rv", 32'(rv0 | rv1), 32'd0);
        chk("stray_data", 32'(rdata), 32'hA55A);
        chk("stray_busy", 32'(busy), 32'd0);
        sd_rdy = 1'b0;

        // Data on the very cycle the timer expires: data wins.
        req0 = 1'b1; addr0 = 22'd5;
        step();
        chk("exp_gnt0", 32'(gnt0), 32'd1);
        seen = 0;
        for (int i = 0; i < T; i++) begin
            step();
            seen = seen | 32'(rv0 | rv1);
        end
        chk("exp_no_rv", 32'(seen), 32'd0);
        chk("exp_busy", 32'(busy), 32'd1);
        sd_rdy = 1'b1; sd_data = 16'h1234;
        step();
        chk("exp_rv0",  32'(rv0), 32'd1);
        chk("exp_err",  32'(err), 32'd0);
        chk("exp_data", 32'(rdata), 32'h1234);
        req0 = 1'b0; sd_rdy = 1'b0;
        step();

        // Port 1 with no data_rdy: IDLE, ISSUE, T WAIT cycles, then DONE,
        // so rvalid is seen T+2 edges after the request is presented.
        req1 = 1'b1; addr1 = 22'h3FFFFF;
        k = 0;
        do begin
            step();
            k++;
        end while (!rv1 && k < T + 10);
        chk("to_latency", 32'(k), 32'(T + 2));
        chk("to_err",  32'(err), 32'd1);
        chk("to_data", 32'(rdata), 32'd0);
        chk("to_rv0",  32'(rv0), 32'd0);
        req1 = 1'b0;
        step();
        chk("to_err_drop", 32'(err), 32'd0);
        req1 = 1'b1; addr1 = 22'd7;
        wait_gnt("to_next_gnt_seen");
        chk("to_next_gnt1", 32'(gnt1), 32'd1);
        chk("to_next_addr", 32'(sd_addr), 32'd7);
        sd_rdy = 1'b1; sd_data = 16'hBEEF;
        step();
        step();
        chk("to_next_rv1",  32'(rv1), 32'd1);
        chk("to_next_err",  32'(err), 32'd0);
        chk("to_next_data", 32'(rdata), 32'hBEEF);
        req1 = 1'b0; sd_rdy = 1'b0;
        step();

        // Serve port 0 so the history points at port 0, then abort a port 1
        // read with reset; afterwards contention must again favour port 0.
        req0 = 1'b1; addr0 = 22'h11;
        wait_gnt("rs_pre_gnt_seen");
        sd_rdy = 1'b1; sd_data = 16'h0101;
        step();
        step();
        chk("rs_pre_rv0", 32'(rv0), 32'd1);
        req0 = 1'b0; sd_rdy = 1'b0;
        step();
        req1 = 1'b1; addr1 = 22'h22;
        wait_gnt("rs_gnt_seen");
        chk("rs_gnt1", 32'(gnt1), 32'd1);
        step();
        step();
        chk("rs_in_wait", 32'(busy), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("rs_pulses", 32'({gnt0, gnt1, rv0, rv1, err, busy, cmd}), 32'd0);
        chk("rs_addr",   32'(sd_addr), 32'd0);
        chk("rs_rdata",  32'(rdata),   32'd0);
        req1 = 1'b0;
        step();
        reset = 1'b0;
        sd_rdy = 1'b1; sd_data = 16'h7777;
        step();
        chk("rs_late_rdy_rv", 32'(rv0 | rv1 | err), 32'd0);
        chk("rs_late_rdy_data", 32'(rdata), 32'd0);
        sd_rdy = 1'b0;
        req0 = 1'b1; addr0 = 22'h33;
        req1 = 1'b1; addr1 = 22'h44;
        wait_gnt("rs_after_gnt_seen");
        chk("rs_after_gnt0", 32'(gnt0), 32'd1);
        chk("rs_after_gnt1", 32'(gnt1), 32'd0);
        chk("rs_after_addr", 32'(sd_addr), 32'h33);
        sd_rdy = 1'b1; sd_data = 16'h5A5A;
        step();
        step();
        chk("rs_after_rv0",  32'(rv0), 32'd1);
        chk("rs_after_data", 32'(rdata), 32'h5A5A);
        req0 = 1'b0; req1 = 1'b0; sd_rdy = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
